// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: stage encodings, memory-bus codes, writeback classes and the memory-stage bus decode
package stage_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd7
  } stage_e;
  localparam logic [1:0] MEM_READ  = 2'b00;
  localparam logic [1:0] MEM_WRITE = 2'b01;
  localparam logic [1:0] MEM_HIZ   = 2'b11;
  localparam logic [1:0] WB_RF     = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_NONE   = 2'd2;
  function automatic logic [1:0] mem_op(input logic nop, input logic [1:0] cls, input logic ma);
    return nop ? MEM_HIZ : (cls == WB_MEM) ? MEM_WRITE : (cls == WB_RF && !ma) ? MEM_READ : MEM_HIZ;
  endfunction
endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// wait_timer: counts consecutive wait cycles (clk, rst, clear, count_en in; expired out), expires on a wait cycle once WAIT_MAX are already counted
module wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : (count_en && cnt_q != W'(WAIT_MAX)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expired = (WAIT_MAX > 0) && count_en && (cnt_q == W'(WAIT_MAX));
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: clocked instruction stage FSM (Clock/Reset/Run/decoder class/Mem_Ready in; Stage, datapath enables, memory controls, retire count, Fault out)
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter bit SKIP_NOP = 1'b1,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic             NOP_FLAG,
  input  logic [1:0]       WillWriteTo_RF_M_Z_Z,
  input  logic             MA_Select_Memory_Stage,
  input  logic             Mem_Ready,
  output logic [2:0]       Stage,
  output logic             IR_Enable,
  output logic             PC_Enable,
  output logic             RA_Enable,
  output logic             RB_Enable,
  output logic             RZ_Enable,
  output logic             RM_Enable,
  output logic             RY_Enable,
  output logic             MA_Select,
  output logic [1:0]       MEM_r_w_z_z,
  output logic             RF_WRITE,
  output logic             Instr_Done,
  output logic [CNT_W-1:0] Instr_Count,
  output logic             Fault
);
  stage_e           stage_q, stage_d;
  logic             nop_q, nop_d, ma_q, ma_d;
  logic [1:0]       cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting, retire, expired, skip;
  logic [1:0]       mem_op_q;
  assign mem_op_q = mem_op(nop_q, cls_q, ma_q);
  assign skip     = SKIP_NOP && NOP_FLAG;
  assign waiting  = (stage_q == ST_FETCH) || (stage_q == ST_MEMORY && mem_op_q != MEM_HIZ);
  assign retire   = (stage_q == ST_WRITEBACK) || (stage_q == ST_DECODE && skip);
  wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk      (Clock),
    .rst      (Reset),
    .clear    (!waiting || Mem_Ready),
    .count_en (waiting && !Mem_Ready),
    .expired  (expired)
  );
  always_comb begin
    case (stage_q)
      ST_IDLE:      stage_d = Run ? ST_FETCH : ST_IDLE;
      ST_FETCH:     stage_d = expired ? ST_FAULT : Mem_Ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:    stage_d = skip ? (Run ? ST_FETCH : ST_IDLE) : ST_EXECUTE;
      ST_EXECUTE:   stage_d = ST_MEMORY;
      ST_MEMORY:    stage_d = expired ? ST_FAULT : (!waiting || Mem_Ready) ? ST_WRITEBACK : ST_MEMORY;
      ST_WRITEBACK: stage_d = Run ? ST_FETCH : ST_IDLE;
      default:      stage_d = ST_FAULT;
    endcase
    nop_d = (stage_q == ST_DECODE) ? NOP_FLAG : nop_q;
    cls_d = (stage_q == ST_DECODE) ? WillWriteTo_RF_M_Z_Z : cls_q;
    ma_d  = (stage_q == ST_DECODE) ? MA_Select_Memory_Stage : ma_q;
    cnt_d = cnt_q + CNT_W'(retire);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stage_q <= ST_IDLE;
      nop_q   <= 1'b0;
      cls_q   <= WB_RF;
      ma_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      nop_q   <= nop_d;
      cls_q   <= cls_d;
      ma_q    <= ma_d;
      cnt_q   <= cnt_d;
    end
  end
  assign Stage       = stage_q;
  assign IR_Enable   = (stage_q == ST_FETCH) && Mem_Ready;
  assign PC_Enable   = IR_Enable;
  assign RA_Enable   = (stage_q == ST_DECODE) && !NOP_FLAG;
  assign RB_Enable   = RA_Enable;
  assign RZ_Enable   = (stage_q == ST_EXECUTE) && !nop_q;
  assign RM_Enable   = RZ_Enable;
  assign RY_Enable   = (stage_q == ST_MEMORY) && !nop_q && (!waiting || Mem_Ready);
  assign MA_Select   = (stage_q == ST_MEMORY || stage_q == ST_WRITEBACK) ? ma_q : 1'b1;
  assign MEM_r_w_z_z = (stage_q == ST_FETCH) ? MEM_READ : (stage_q == ST_MEMORY) ? mem_op_q : MEM_HIZ;
  assign RF_WRITE    = (stage_q == ST_WRITEBACK) && cls_q == WB_RF && !nop_q;
  assign Instr_Done  = retire;
  assign Instr_Count = cnt_q;
  assign Fault       = (stage_q == ST_FAULT);
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed table and corner-case sequences for stage_sequencer
module tb_stage_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, run, nop, mas, mr, run_b, nop_b, mas_b, mr_b;
  logic [1:0] wb, wb_b;
  logic [2:0] st_a, st_b;
  logic [6:0] en_a, en_b;
  logic ma_a, ma_b, rf_a, rf_b, dn_a, dn_b, ft_a, ft_b;
  logic [1:0] mem_a, mem_b;
  logic [15:0] cnt_a;
  logic [3:0] cnt_b;
  int errors = 0, checks = 0;
  stage_sequencer #(.SKIP_NOP(1'b1), .WAIT_MAX(4), .CNT_W(16)) dut_a (
    .Clock(clk), .Reset(rst), .Run(run), .NOP_FLAG(nop), .WillWriteTo_RF_M_Z_Z(wb),
    .MA_Select_Memory_Stage(mas), .Mem_Ready(mr), .Stage(st_a),
    .IR_Enable(en_a[6]), .PC_Enable(en_a[5]), .RA_Enable(en_a[4]), .RB_Enable(en_a[3]),
    .RZ_Enable(en_a[2]), .RM_Enable(en_a[1]), .RY_Enable(en_a[0]), .MA_Select(ma_a),
    .MEM_r_w_z_z(mem_a), .RF_WRITE(rf_a), .Instr_Done(dn_a), .Instr_Count(cnt_a), .Fault(ft_a)
  );
  stage_sequencer #(.SKIP_NOP(1'b0), .WAIT_MAX(0), .CNT_W(4)) dut_b (
    .Clock(clk), .Reset(rst), .Run(run_b), .NOP_FLAG(nop_b), .WillWriteTo_RF_M_Z_Z(wb_b),
    .MA_Select_Memory_Stage(mas_b), .Mem_Ready(mr_b), .Stage(st_b),
    .IR_Enable(en_b[6]), .PC_Enable(en_b[5]), .RA_Enable(en_b[4]), .RB_Enable(en_b[3]),
    .RZ_Enable(en_b[2]), .RM_Enable(en_b[1]), .RY_Enable(en_b[0]), .MA_Select(ma_b),
    .MEM_r_w_z_z(mem_b), .RF_WRITE(rf_b), .Instr_Done(dn_b), .Instr_Count(cnt_b), .Fault(ft_b)
  );
  typedef struct {
    logic        run, nop, mas, mr;
    logic [1:0]  wb;
    logic [15:0] exp, cnt;
  } vec_t;
  vec_t v[30];
  function automatic logic [15:0] x(input logic [2:0] st, input logic [6:0] en, input logic ma,
                                    input logic [1:0] mem, input logic [2:0] rdf);
    return {st, en, ma, mem, rdf};
  endfunction
  function automatic vec_t mk(input logic r, input logic n, input logic [1:0] w, input logic m,
                              input logic y, input logic [15:0] e, input logic [15:0] c);
    vec_t t;
    t.run = r; t.nop = n; t.wb = w; t.mas = m; t.mr = y; t.exp = e; t.cnt = c;
    return t;
  endfunction
  task automatic chk(input bit b, input string nm, input logic [15:0] e, input logic [15:0] c);
    logic [15:0] act, ac;
    @(negedge clk);
    act = b ? {st_b, en_b, ma_b, mem_b, rf_b, dn_b, ft_b} : {st_a, en_a, ma_a, mem_a, rf_a, dn_a, ft_a};
    ac  = b ? {12'd0, cnt_b} : cnt_a;
    checks++;
    if (act !== e || ac !== c) begin
      errors++;
      $display("FAIL %s: outputs=%h count=%h, required outputs=%h count=%h", nm, act, ac, e, c);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    logic [15:0] idle_x, fetch_x, fwait_x;
    idle_x  = x(3'd0, 7'b0, 1'b1, 2'b11, 3'b000);
    fetch_x = x(3'd1, 7'b1100000, 1'b1, 2'b00, 3'b000);
    fwait_x = x(3'd1, 7'b0, 1'b1, 2'b00, 3'b000);
    v[0]  = mk(0, 0, 2'd0, 1, 1, idle_x, 0);
    v[1]  = mk(1, 0, 2'd0, 1, 1, idle_x, 0);
    v[2]  = mk(1, 0, 2'd0, 1, 1, fetch_x, 0);
    v[3]  = mk(1, 0, 2'd0, 1, 1, x(3'd2, 7'b0011000, 1, 2'b11, 3'b000), 0);
    v[4]  = mk(1, 1, 2'd2, 0, 1, x(3'd3, 7'b0000110, 1, 2'b11, 3'b000), 0);
    v[5]  = mk(1, 1, 2'd2, 0, 0, x(3'd4, 7'b0000001, 1, 2'b11, 3'b000), 0);
    v[6]  = mk(1, 1, 2'd2, 0, 0, x(3'd5, 7'b0, 1, 2'b11, 3'b110), 0);
    v[7]  = mk(1, 0, 2'd0, 1, 0, fwait_x, 1);
    v[8]  = mk(1, 0, 2'd0, 1, 0, fwait_x, 1);
    v[9]  = mk(1, 0, 2'd0, 1, 0, fwait_x, 1);
    v[10] = mk(1, 0, 2'd0, 1, 1, fetch_x, 1);
    v[11] = mk(1, 0, 2'd1, 0, 1, x(3'd2, 7'b0011000, 1, 2'b11, 3'b000), 1);
    v[12] = mk(1, 0, 2'd0, 1, 1, x(3'd3, 7'b0000110, 1, 2'b11, 3'b000), 1);
    v[13] = mk(1, 0, 2'd0, 1, 0, x(3'd4, 7'b0, 0, 2'b01, 3'b000), 1);
    v[14] = mk(1, 0, 2'd0, 1, 0, x(3'd4, 7'b0, 0, 2'b01, 3'b000), 1);
    v[15] = mk(1, 0, 2'd0, 1, 1, x(3'd4, 7'b0000001, 0, 2'b01, 3'b000), 1);
    v[16] = mk(0, 0, 2'd0, 1, 1, x(3'd5, 7'b0, 0, 2'b11, 3'b010), 1);
    v[17] = mk(0, 0, 2'd0, 1, 1, idle_x, 2);
    v[18] = mk(1, 0, 2'd0, 1, 1, idle_x, 2);
    v[19] = mk(1, 0, 2'd0, 1, 1, fetch_x, 2);
    v[20] = mk(1, 0, 2'd0, 0, 1, x(3'd2, 7'b0011000, 1, 2'b11, 3'b000), 2);
    v[21] = mk(1, 0, 2'd0, 1, 1, x(3'd3, 7'b0000110, 1, 2'b11, 3'b000), 2);
    v[22] = mk(1, 0, 2'd0, 1, 0, x(3'd4, 7'b0, 0, 2'b00, 3'b000), 2);
    v[23] = mk(1, 0, 2'd0, 1, 1, x(3'd4, 7'b0000001, 0, 2'b00, 3'b000), 2);
    v[24] = mk(1, 0, 2'd0, 1, 1, x(3'd5, 7'b0, 0, 2'b11, 3'b110), 2);
    v[25] = mk(1, 0, 2'd0, 1, 1, fetch_x, 3);
    v[26] = mk(1, 1, 2'd0, 1, 1, x(3'd2, 7'b0, 1, 2'b11, 3'b010), 3);
    v[27] = mk(0, 0, 2'd0, 1, 1, fetch_x, 4);
    v[28] = mk(0, 1, 2'd0, 1, 1, x(3'd2, 7'b0, 1, 2'b11, 3'b010), 4);
    v[29] = mk(0, 0, 2'd0, 1, 1, idle_x, 5);
    rst = 1; run = 0; nop = 0; wb = 0; mas = 1; mr = 0;
    run_b = 0; nop_b = 0; wb_b = 0; mas_b = 0; mr_b = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 30; i++) begin
      run = v[i].run; nop = v[i].nop; wb = v[i].wb; mas = v[i].mas; mr = v[i].mr;
      chk(0, $sformatf("vec%0d", i), v[i].exp, v[i].cnt);
    end
    run = 1; mr = 1; nop = 0; wb = 2'd1; mas = 0;
    chk(0, "mid_idle", idle_x, 5);
    chk(0, "mid_fetch", fetch_x, 5);
    chk(0, "mid_decode", x(3'd2, 7'b0011000, 1, 2'b11, 3'b000), 5);
    chk(0, "mid_execute", x(3'd3, 7'b0000110, 1, 2'b11, 3'b000), 5);
    mr = 0;
    chk(0, "mid_memory", x(3'd4, 7'b0, 0, 2'b01, 3'b000), 5);
    rst = 1; @(posedge clk); #1; rst = 0; run = 0;
    chk(0, "mid_reset", idle_x, 0);
    run = 1; mr = 0;
    chk(0, "to_fetch", idle_x, 0);
    for (int i = 0; i < 5; i++) chk(0, $sformatf("fetch_wait%0d", i), fwait_x, 0);
    chk(0, "fault", x(3'd7, 7'b0, 1, 2'b11, 3'b001), 0);
    mr = 1;
    for (int i = 0; i < 2; i++) chk(0, "fault_sticky", x(3'd7, 7'b0, 1, 2'b11, 3'b001), 0);
    rst = 1; @(posedge clk); #1; rst = 0; run = 0;
    chk(0, "fault_reset", idle_x, 0);
    run_b = 1; mr_b = 1; nop_b = 1; wb_b = 2'd0; mas_b = 0;
    chk(1, "b_idle", idle_x, 0);
    chk(1, "b_fetch", fetch_x, 0);
    chk(1, "b_nop_decode", x(3'd2, 7'b0, 1, 2'b11, 3'b000), 0);
    chk(1, "b_nop_execute", x(3'd3, 7'b0, 1, 2'b11, 3'b000), 0);
    chk(1, "b_nop_memory", x(3'd4, 7'b0, 0, 2'b11, 3'b000), 0);
    chk(1, "b_nop_wb", x(3'd5, 7'b0, 0, 2'b11, 3'b010), 0);
    chk(1, "b_fetch2", fetch_x, 1);
    repeat (69) @(posedge clk);
    #1;
    chk(1, "b_cnt_f", fetch_x, 15);
    repeat (3) @(posedge clk);
    #1 run_b = 0;
    chk(1, "b_wrap_wb", x(3'd5, 7'b0, 0, 2'b11, 3'b010), 15);
    chk(1, "b_wrap", idle_x, 0);
    run_b = 1; mr_b = 0; nop_b = 0;
    chk(1, "b_to_fetch", idle_x, 0);
    repeat (20) @(posedge clk);
    #1;
    chk(1, "b_no_timeout", fwait_x, 0);
    mr_b = 1;
    chk(1, "b_fetch_done", fetch_x, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
